// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one operand bit per clock through a single full-adder cell.
// Define SERIAL_ADDER_OVF_EN to compile in the signed-overflow register; otherwise ovf is tied to 0.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             s_bit, c_bit, last_bit;

    assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_bit    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    // Next-state logic: operand capture in IDLE, one full-adder step per RUN cycle
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_sh_d  = {s_bit, s_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = c_bit;
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (last_bit) begin
                    sum_d   = {s_bit, s_sh_q[WIDTH-1:1]};
                    cout_d  = c_bit;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            s_sh_q  <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow is carry into the MSB xor carry out of it, latched on the last bit
    always_comb begin
        ovf_d = ovf_q;
        if (last_bit) begin
            ovf_d = carry_q ^ c_bit;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: an 8-bit instance for directed/random ops and a
// 4-bit instance for the exhaustive sweep, both checked every cycle against an arithmetic model.
module tb_serial_adder_n;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       st4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: unsigned result, borrow/carry and signed range test
    task automatic predict(input int w, input int av, input int bv, input bit sb,
                           output int s, output bit co, output bit ov);
        int mask, half, sa, sbv, r;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        s    = (sb ? av - bv : av + bv) & mask;
        co   = sb ? (av >= bv) : ((av + bv) > mask);
        sa   = (av >= half) ? av - (1 << w) : av;
        sbv  = (bv >= half) ? bv - (1 << w) : bv;
        r    = sb ? sa - sbv : sa + sbv;
        ov   = OVF_ON && ((r < -half) || (r > half - 1));
    endtask

    bit run_m[2], m_busy[2], m_done[2], m_co[2], m_ov[2], pco[2], pov[2];
    int due_m[2], psum[2], m_sum[2];

    // Timing model: accept when idle, commit WIDTH edges later, reset clears everything
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            automatic int w  = (d == 0) ? 8 : 4;
            automatic bit st = (d == 0) ? st8 : st4;
            automatic bit sb = (d == 0) ? sub8 : sub4;
            automatic int av = (d == 0) ? int'(a8) : int'(a4);
            automatic int bv = (d == 0) ? int'(b8) : int'(b4);
            automatic int ps;
            automatic bit pc, pv;
            if (rst) begin
                run_m[d] <= 1'b0; m_busy[d] <= 1'b0; m_done[d] <= 1'b0;
                m_sum[d] <= 0;    m_co[d]   <= 1'b0; m_ov[d]   <= 1'b0;
            end else begin
                m_done[d] <= 1'b0;
                if (run_m[d] && cyc == due_m[d]) begin
                    run_m[d] <= 1'b0; m_busy[d] <= 1'b0; m_done[d] <= 1'b1;
                    m_sum[d] <= psum[d]; m_co[d] <= pco[d]; m_ov[d] <= pov[d];
                end else if (!run_m[d] && st) begin
                    predict(w, av, bv, sb, ps, pc, pv);
                    psum[d] <= ps; pco[d] <= pc; pov[d] <= pv;
                    due_m[d] <= cyc + w; run_m[d] <= 1'b1; m_busy[d] <= 1'b1;
                end
            end
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_w8", busy8, m_busy[0]);
            check("done_w8", done8, m_done[0]);
            check("sum_w8",  sum8,  m_sum[0]);
            check("cout_w8", cout8, m_co[0]);
            check("ovf_w8",  ovf8,  m_ov[0]);
            check("busy_w4", busy4, m_busy[1]);
            check("done_w4", done4, m_done[1]);
            check("sum_w4",  sum4,  m_sum[1]);
            check("cout_w4", cout4, m_co[1]);
            check("ovf_w4",  ovf4,  m_ov[1]);
        end
    end

    // One 8-bit op; optionally disturbs inputs mid-RUN. Checks latency and busy length.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sb, input bit disturb);
        int n, busyc;
        st8 = 1'b1; a8 = av; b8 = bv; sub8 = sb;
        @(negedge clk);
        st8 = 1'b0;
        busyc = busy8 ? 1 : 0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (busy8) busyc++;
            if (disturb && n == 3) begin st8 = 1'b1; a8 = ~av; b8 = 8'h5A; sub8 = ~sb; end
            if (disturb && n == 4) st8 = 1'b0;
            if (done8) break;
        end
        check("latency_w8", n, 8);
        check("busy_cycles_w8", busyc, 8);
    endtask

    task automatic expect8(input string nm, input int s, input bit c, input bit v);
        check({nm, "_sum"}, sum8, s);
        check({nm, "_cout"}, cout8, c);
        check({nm, "_ovf"}, ovf8, v);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", busy8, 0);
        check("reset_sum", sum8, 0);
        @(negedge clk);
        rst = 1'b0;

        op8(8'h3C, 8'h05, 1'b0, 1'b0); expect8("add_3c_05", 'h41, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0); expect8("add_ff_01", 'h00, 1'b1, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0); expect8("add_7f_01", 'h80, 1'b0, OVF_ON);
        op8(8'h05, 8'h07, 1'b1, 1'b0); expect8("sub_05_07", 'hFE, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 1'b0); expect8("sub_80_01", 'h7F, 1'b1, OVF_ON);
        op8(8'h12, 8'h34, 1'b0, 1'b1); expect8("disturbed", 'h46, 1'b0, 1'b0);

        // Start asserted in the done cycle is accepted; second done 8 clocks later
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        n = 0;
        while (n < 20 && !done8) begin @(negedge clk); n++; end
        st8 = 1'b1; a8 = 8'h40; b8 = 8'h41; sub8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        check("b2b_accept_busy", busy8, 1);
        n = 0;
        while (n < 20) begin @(negedge clk); n++; if (done8) break; end
        check("b2b_latency", n, 8);
        expect8("b2b_sub_40_41", 'hFF, 1'b0, 1'b0);

        // Reset after three processed bits aborts the operation
        st8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        expect8("abort", 'h00, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("abort_no_late_done", done8, 0);

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Exhaustive 4-bit sweep with start held high: accept every WIDTH+1 edges
        st4 = 1'b1; a4 = 4'h0; b4 = 4'h0; sub4 = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 512; i++) begin
            a4 = 4'(i % 16); b4 = 4'((i / 16) % 16); sub4 = 1'((i / 256) % 2);
            if (i == 512) st4 = 1'b0;
            repeat (5) @(negedge clk);
        end
        st4 = 1'b0;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
